universal_shift_seq: RTL and testbench
======================================

UNIVERSAL_SHIFT_SEQ -- requirements
Module: universal_shift_seq

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 Parameter: CNT_W, default 4, width of the step-count field.
REQ-003 Port: Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: Reset  input  1  asynchronous, active-high reset.
REQ-005 Port: Start  input  1  request to begin an operation; sampled only when Busy=0.
REQ-006 Port: S  input  3  operation select, latched at accepted Start.
REQ-007 Port: Count  input  CNT_W  number of steps, latched at accepted Start.
REQ-008 Port: L  input  WIDTH  parallel load data, latched at accepted Start.
REQ-009 Port: Q  output  WIDTH  register contents.
REQ-010 Port: Busy  output  1  operation in progress.
REQ-011 Port: Done  output  1  single-cycle completion pulse.
REQ-012 Port: ShiftOut  output  1  bit displaced by the most recent shift/rotate step.
REQ-013 Ports (USHIFT_SERIAL_IN_EN only): SerInL  input  1 (fill bit entering LSB); SerInR  input  1 (fill bit entering MSB).

Function
REQ-014 S encoding SHALL be: 000 hold, 001 shift left logical, 010 shift right logical, 011 shift right arithmetic, 100 rotate left, 101 rotate right, 110 hold, 111 parallel load.
REQ-015 FSM SHALL have states IDLE, RUN, FIN; Busy=1 in RUN and FIN only.
REQ-016 IDLE: Start=1 at edge t SHALL latch S, Count, L, set Busy, enter RUN; Q unchanged at edge t.
REQ-017 RUN: each edge applies one step of latched op to Q and decrements remaining count; after last step FSM enters FIN.
REQ-018 Latched Count=N>=1: steps at edges t+1..t+N; Done=1 and Busy=0 for the cycle after edge t+N+1 (FIN->IDLE transition asserts Done for exactly one cycle).
REQ-019 Latched Count=0 with shift/rotate/hold op: no step; RUN->FIN at edge t+1, Done pulse after edge t+2; Q unchanged.
REQ-020 Parallel load: Q<=latched L at edge t+1 regardless of Count; then FIN as for N=1.
REQ-021 Shift left step: Q<={Q[WIDTH-2:0],fill}, ShiftOut<=Q[WIDTH-1]; fill=0 (or SerInL under macro).
REQ-022 Shift right logical step: Q<={fill,Q[WIDTH-1:1]}, ShiftOut<=Q[0]; fill=0 (or SerInR under macro).
REQ-023 Arithmetic right step: MSB replicated, ShiftOut<=Q[0]; serial input never used.
REQ-024 Rotate left/right: wrapped bit re-enters opposite end and is also driven to ShiftOut.
REQ-025 Hold and load SHALL leave ShiftOut unchanged.
REQ-026 Start while Busy=1 SHALL be ignored and SHALL not alter latched S/Count/L.
REQ-027 S, Count, L changes after acceptance SHALL not affect the running operation.
REQ-028 Count SHALL be treated as unsigned; max value 2^CNT_W-1 steps; rotate by WIDTH returns Q to its start value.

Reset
REQ-029 Reset=1 SHALL immediately force Q=0, ShiftOut=0, Busy=0, Done=0, FSM=IDLE, internal count=0, regardless of clock.
REQ-030 Reset asserted mid-operation SHALL abort it with no Done pulse; first Start after deassertion is accepted normally.

Configuration
REQ-031 Macro USHIFT_SERIAL_IN_EN defined: SerInL/SerInR ports exist and supply logical-shift fill bits sampled at each step edge.
REQ-032 Macro undefined: ports absent; logical-shift fill bit is constant 0; all other behaviour identical.

Verification (WIDTH=8, CNT_W=4)
REQ-033 Reset, Start S=111 L=0xA5 -> Q=0xA5 at edge t+1, single Done pulse, Busy low afterwards.
REQ-034 Q=0x81, Start S=100 Count=3 -> Q=0x0C after 3 steps, ShiftOut=0, Done once; Count=8 rotate -> Q=0x81 restored.
REQ-035 Q=0x90, Start S=011 Count=2 -> Q=0xE4, ShiftOut=0; S=010 Count=2 from 0x90 -> Q=0x24.
REQ-036 Start S=001 Count=0 on Q=0x3C -> Q stays 0x3C, Done pulse after edge t+2; Start pulsed while Busy -> ignored.
REQ-037 Reset raised mid-run of S=001 Count=15 -> Q=0, Busy=0, no Done; subsequent load accepted.
REQ-038 With USHIFT_SERIAL_IN_EN, SerInL=1, Q=0x00, S=001 Count=4 -> Q=0x0F.

Source files
------------

// File: rtl/universal_shift_seq.sv
// Sequenced universal shift register: hold, logical/arithmetic shift, rotate and parallel load over a latched step count.
// Optional build macro USHIFT_SERIAL_IN_EN adds SerInL/SerInR fill-bit inputs for the logical shifts.
module universal_shift_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       S,
   input  logic [CNT_W-1:0] Count,
   input  logic [WIDTH-1:0] L,
`ifdef USHIFT_SERIAL_IN_EN
   input  logic             SerInL,
   input  logic             SerInR,
`endif
   output logic [WIDTH-1:0] Q,
   output logic             Busy,
   output logic             Done,
   output logic             ShiftOut
);

   localparam logic [2:0] OP_SLL  = 3'b001;
   localparam logic [2:0] OP_SRL  = 3'b010;
   localparam logic [2:0] OP_SRA  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
   localparam logic [2:0] OP_LOAD = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIN  = 2'b10
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [2:0]         op_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   load_r;
   logic               accept;
   logic               step_en;
   logic               load_en;
   logic               fill_l;
   logic               fill_r;
   logic [WIDTH:0]     step_res;

`ifdef USHIFT_SERIAL_IN_EN
   assign fill_l = SerInL;
   assign fill_r = SerInR;
`else
   assign fill_l = 1'b0;
   assign fill_r = 1'b0;
`endif

   // One step of the selected operation; result is {displaced bit, new register value}.
   function automatic logic [WIDTH:0] step_f(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] q,
      input logic             so,
      input logic             fl,
      input logic             fr
   );
      logic signed [WIDTH-1:0] qs;
      logic [WIDTH:0]          res;
      qs  = q;
      res = {so, q};
      case (op)
         OP_SLL:  res = {q[WIDTH-1], q[WIDTH-2:0], fl};
         OP_SRL:  res = {q[0], fr, q[WIDTH-1:1]};
         OP_SRA:  res = {q[0], qs >>> 1};
         OP_ROL:  res = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
         OP_ROR:  res = {q[0], q[0], q[WIDTH-1:1]};
         default: res = {so, q};
      endcase
      return res;
   endfunction

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step_en   = 1'b0;
      load_en   = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            // Load finishes in one edge regardless of count; a zero count just falls through.
            if (op_r == OP_LOAD) begin
               load_en   = 1'b1;
               state_nxt = FIN;
            end else if (cnt_r == '0) begin
               state_nxt = FIN;
            end else begin
               step_en = 1'b1;
               if (cnt_r == CNT_W'(1)) begin
                  state_nxt = FIN;
               end
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign Busy     = (state != IDLE);
   assign step_res = step_f(op_r, Q, ShiftOut, fill_l, fill_r);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         op_r     <= '0;
         cnt_r    <= '0;
         load_r   <= '0;
         Q        <= '0;
         ShiftOut <= 1'b0;
      end else begin
         if (accept) begin
            op_r   <= S;
            cnt_r  <= Count;
            load_r <= L;
         end
         if (step_en) begin
            cnt_r    <= cnt_r - CNT_W'(1);
            Q        <= step_res[WIDTH-1:0];
            ShiftOut <= step_res[WIDTH];
         end
         if (load_en) begin
            Q <= load_r;
         end
      end
   end

   // Done is registered off FIN so it lands in the cycle after the FIN->IDLE edge.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Done <= 1'b0;
      end else begin
         Done <= (state == FIN);
      end
   end

endmodule

// File: tb/tb_universal_shift_seq.sv
// Randomized self-checking bench for universal_shift_seq against an operation-level reference model.
module tb_universal_shift_seq;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [2:0]    s;
   logic [CW-1:0] cnt;
   logic [W-1:0]  l;
   logic [W-1:0]  q;
   logic          busy;
   logic          done;
   logic          so;
   logic          fill_l = 1'b0;
   logic          fill_r = 1'b0;

   logic [W-1:0]  mq;
   logic          mso;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   universal_shift_seq #(.WIDTH(W), .CNT_W(CW)) dut (
      .Clock    (clk),
      .Reset    (rst),
      .Start    (start),
      .S        (s),
      .Count    (cnt),
      .L        (l),
`ifdef USHIFT_SERIAL_IN_EN
      .SerInL   (fill_l),
      .SerInR   (fill_r),
`endif
      .Q        (q),
      .Busy     (busy),
      .Done     (done),
      .ShiftOut (so)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Whole-operation model: N steps computed at once with plain shifts on a wide word.
   task automatic model_op(input logic [2:0] op, input int n, input logic [W-1:0] ld);
      logic [63:0]        q64;
      logic [63:0]        mask;
      logic [63:0]        r;
      logic signed [63:0] sx;
      int                 k;
      mask = (64'd1 << W) - 64'd1;
      q64  = 64'(mq);
      sx   = signed'({{(64-W){mq[W-1]}}, mq});
      r    = q64;
      case (op)
         3'b001: if (n > 0) begin
            mso = (n <= W) ? q64[W-n] : fill_l;
            r   = (q64 << n) | (fill_l ? ((64'd1 << n) - 64'd1) : 64'd0);
         end
         3'b010: if (n > 0) begin
            mso = (n <= W) ? q64[n-1] : fill_r;
            r   = (q64 >> n) | (fill_r ? (mask & ~(mask >> n)) : 64'd0);
         end
         3'b011: if (n > 0) begin
            mso = sx[n-1];
            r   = 64'(sx >>> n);
         end
         3'b100: if (n > 0) begin
            k   = n % W;
            r   = (q64 << k) | (q64 >> (W - k));
            mso = r[0];
         end
         3'b101: if (n > 0) begin
            k   = n % W;
            r   = (q64 >> k) | (q64 << (W - k));
            mso = r[W-1];
         end
         default: ;
      endcase
      if (op == 3'b111) mq = ld;
      else mq = W'(r & mask);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [CW-1:0] n, input logic [W-1:0] ld,
                         input string tag);
      logic [W-1:0] q_before;
      int           e;
      int           seen;
      @(negedge clk);
      start = 1'b1;
      s     = op;
      cnt   = n;
      l     = ld;
      q_before = mq;
      @(posedge clk);
      #1;
      check({tag, "_accept_q"}, 64'(q), 64'(q_before));
      check({tag, "_accept_busy"}, 64'(busy), 64'd1);
      // Garbage on the inputs plus a Start pulse while busy must not disturb the operation.
      start = 1'b1;
      s     = 3'($urandom_range(0, 7));
      cnt   = CW'($urandom_range(0, 15));
      l     = W'($urandom);
      model_op(op, int'(n), ld);
      e    = (op == 3'b111 || n == 0) ? 1 : int'(n);
      seen = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) start = 1'b0;
         if (done) begin
            seen = i;
            break;
         end
      end
      check({tag, "_done_latency"}, 64'(seen), 64'(e + 1));
      check({tag, "_q"}, 64'(q), 64'(mq));
      check({tag, "_shiftout"}, 64'(so), 64'(mso));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      check({tag, "_done_single"}, 64'(done), 64'd0);
   endtask

   initial begin
      int seen;
      rst   = 1'b0;
      start = 1'b0;
      s     = '0;
      cnt   = '0;
      l     = '0;
      mq    = '0;
      mso   = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("reset_q", 64'(q), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_shiftout", 64'(so), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(3'b111, 4'd0, 8'hA5, "load_a5");
      check("load_a5_const", 64'(q), 64'hA5);

      run_op(3'b111, 4'd5, 8'h81, "load_81");
      run_op(3'b100, 4'd3, 8'h00, "rol3");
      check("rol3_const", 64'(q), 64'h0C);
      check("rol3_so_const", 64'(so), 64'd0);
      run_op(3'b111, 4'd0, 8'h81, "load_81b");
      run_op(3'b100, 4'd8, 8'h00, "rol8");
      check("rol8_restore", 64'(q), 64'h81);

      run_op(3'b111, 4'd0, 8'h90, "load_90");
      run_op(3'b011, 4'd2, 8'h00, "sra2");
      check("sra2_const", 64'(q), 64'hE4);
      check("sra2_so_const", 64'(so), 64'd0);
      run_op(3'b111, 4'd0, 8'h90, "load_90b");
      run_op(3'b010, 4'd2, 8'h00, "srl2");
      check("srl2_const", 64'(q), 64'h24);

      run_op(3'b111, 4'd0, 8'h3C, "load_3c");
      run_op(3'b001, 4'd0, 8'h00, "sll0");
      check("sll0_const", 64'(q), 64'h3C);

      // Abort a long shift with an asynchronous reset between clock edges.
      @(negedge clk);
      start = 1'b1;
      s     = 3'b001;
      cnt   = 4'd15;
      l     = 8'h55;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("abort_q", 64'(q), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_shiftout", 64'(so), 64'd0);
      mq  = '0;
      mso = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) seen = 1;
      end
      check("abort_no_done", 64'(seen), 64'd0);
      run_op(3'b111, 4'd0, 8'h5A, "load_after_abort");

`ifdef USHIFT_SERIAL_IN_EN
      run_op(3'b111, 4'd0, 8'h00, "load_00");
      fill_l = 1'b1;
      run_op(3'b001, 4'd4, 8'h00, "ser_sll4");
      check("ser_sll4_const", 64'(q), 64'h0F);
      fill_l = 1'b0;
`endif

      for (int i = 0; i < 60; i++) begin
         run_op(3'($urandom_range(0, 7)), CW'($urandom_range(0, 15)), W'($urandom), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
